bin_to_bcd_seq: RTL

Sequential, parametrised binary-to-BCD converter for the display path. It replaces combinational conversion with a one-bit-per-cycle double-dabble engine, which keeps area and timing flat for wide operands. It takes a WIDTH-bit operand through a valid/ready handshake and returns DIGITS packed BCD digits plus a sign flag. It supports per-transaction signed or unsigned interpretation and flags results that do not fit in DIGITS digits.

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bin_to_bcd_seq_if.sv | 26 ++
 rtl/bin_to_bcd_seq_digit_adj.sv | 11 +
 rtl/bin_to_bcd_seq.sv | 112 +++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      DONE    = 2'd2
   } state_t;

   typedef logic [3:0] bcd_digit_t;

   // Digits needed to show every WIDTH-bit unsigned value: ceil(width * log10(2)).
   // Fixed-point log10(2) = 0.30103 is exact enough for any practical width.
   function automatic int min_digits(input int width);
      return (width * 30103 + 99999) / 100000;
   endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Operand/result handshake bundle between a producer and the BCD converter.
interface bin_to_bcd_seq_if #(
   parameter int WIDTH  = 32,
   parameter int DIGITS = 10
) ();
   logic                  in_valid;
   logic                  in_ready;
   logic [WIDTH-1:0]      binary;
   logic                  signed_mode;
   logic                  out_valid;
   logic                  out_ready;
   logic [4*DIGITS-1:0]   bcd;
   logic                  neg;
   logic                  overflow;
   logic                  busy;

   modport master (
      output in_valid, binary, signed_mode, out_ready,
      input  in_ready, out_valid, bcd, neg, overflow, busy
   );

   modport slave (
      input  in_valid, binary, signed_mode, out_ready,
      output in_ready, out_valid, bcd, neg, overflow, busy
   );
endinterface

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// One double-dabble correction cell: a digit of 5..9 gets +3 so the
// following left shift carries correctly into the next decade.
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  bcd_digit_t din,
   output bcd_digit_t dout
);
   // 5..9 map to 8..12, which still fits in four bits
   always_comb dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one operand bit per cycle, WIDTH
// cycles per conversion, signed/unsigned per transaction, sticky overflow.
module bin_to_bcd_seq
   import bcd_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int DIGITS = 10
) (
   input  logic clk,
   input  logic rst_n,
   bin_to_bcd_seq_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t              state;
   logic [WIDTH-1:0]    mag;
   logic [4*DIGITS-1:0] dig;
   logic [CW-1:0]       cnt;
   logic                sticky;
   logic                neg_r;

   logic [4*DIGITS-1:0] bcd_r;
   logic                neg_o;
   logic                ovf_o;
   logic                out_valid_r;
   logic                busy_r;

   logic [4*DIGITS-1:0] dig_adj;
   logic [4*DIGITS-1:0] dig_nxt;
   logic [WIDTH-1:0]    mag_nxt;
   logic                top_bit;
   logic                ovf_nxt;
   logic                accept;
   logic                is_neg;

   // Per-digit +3 correction applied before every shift
   for (genvar i = 0; i < DIGITS; i++) begin : g_adj
      bcd_digit_adj u_adj (
         .din  (dig[4*i +: 4]),
         .dout (dig_adj[4*i +: 4])
      );
   end

   // One shift step: magnitude MSB enters digit 0, top digit bit 3 falls out
   always_comb begin
      {top_bit, dig_nxt, mag_nxt} = {dig_adj, mag, 1'b0};
      ovf_nxt = sticky | top_bit;
   end

   assign bus.in_ready  = (state == IDLE) || (state == DONE && bus.out_ready);
   assign accept        = bus.in_valid && bus.in_ready;
   assign is_neg        = bus.signed_mode && bus.binary[WIDTH-1];

   assign bus.bcd       = bcd_r;
   assign bus.neg       = neg_o;
   assign bus.overflow  = ovf_o;
   assign bus.out_valid = out_valid_r;
   assign bus.busy      = busy_r;

   // Control FSM plus datapath; result registers only load on DONE entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         mag         <= '0;
         dig         <= '0;
         cnt         <= '0;
         sticky      <= 1'b0;
         neg_r       <= 1'b0;
         bcd_r       <= '0;
         neg_o       <= 1'b0;
         ovf_o       <= 1'b0;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else if (accept) begin
         // Fresh operand (from IDLE, or back-to-back out of DONE)
         mag         <= is_neg ? (~bus.binary + WIDTH'(1)) : bus.binary;
         neg_r       <= is_neg;
         dig         <= '0;
         sticky      <= 1'b0;
         cnt         <= CW'(WIDTH - 1);
         state       <= CONVERT;
         busy_r      <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         case (state)
            IDLE: ;
            CONVERT: begin
               dig    <= dig_nxt;
               mag    <= mag_nxt;
               sticky <= ovf_nxt;
               cnt    <= cnt - CW'(1);
               if (cnt == '0) begin
                  state       <= DONE;
                  busy_r      <= 1'b0;
                  out_valid_r <= 1'b1;
                  bcd_r       <= dig_nxt;
                  neg_o       <= neg_r;
                  ovf_o       <= ovf_nxt;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state       <= IDLE;
                  out_valid_r <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
